serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_fa_cell.sv | 22 ++
 rtl/serial_adder.sv | 122 ++++++++++++
 tb/tb_serial_adder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default operand width.
package serial_adder_pkg;

    localparam int SA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder built from two half-adder stages; outputs are gated by the enable.
module serial_fa_cell (
    input  logic i_en,
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    assign w_s1 = i_a ^ i_b;
    assign w_c1 = i_a & i_b;
    assign w_c2 = w_s1 & i_c;

    assign o_s = i_en & (w_s1 ^ i_c);
    assign o_c = i_en & (w_c1 | w_c2);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per enabled cycle, LSB first, with valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add a registered signed-overflow output (ovf).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_e        r_state;
    sa_state_e        w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;

    logic w_load;
    logic w_step;
    logic w_last;
    logic w_take;
    logic w_fa_s;
    logic w_fa_c;

    assign w_load = en & in_valid & (r_state == IDLE);
    assign w_step = en & (r_state == RUN);
    assign w_last = w_step & (r_cnt == LAST);
    assign w_take = en & out_ready & (r_state == DONE);

    serial_fa_cell u_fa (
        .i_en (en),
        .i_a  (r_a[0]),
        .i_b  (r_b[0]),
        .i_c  (r_carry),
        .o_s  (w_fa_s),
        .o_c  (w_fa_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_load) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    if (w_take) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Counter holds at LAST on the final bit so it never wraps within an operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_sum   <= {w_fa_s, r_sum[WIDTH-1:1]};
            r_carry <= w_fa_c;
            r_cnt   <= w_last ? r_cnt : r_cnt + 1'b1;
            if (w_last) r_cout <= w_fa_c;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the last bit r_carry is the carry into the MSB.
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_fa_c;
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = en & (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, scoreboard queue, reset/enable/backpressure sequences.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        int           stall;
        int           gap;
        int           lat;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Caller leaves time just after a negedge; task returns just after a negedge.
    task automatic run_op(input vec_t v);
        int           lat;
        int           n;
        exp_t         e;
        logic [W-1:0] hs;
        logic         hc;
        a = v.a; b = v.b; cin = v.ci; in_valid = 1'b1; out_ready = (v.stall == 0);
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk); n++;
        end
        chk("accept_ready", in_ready, 1);
        sb.push_back('{s: v.s, c: v.c, o: v.o});
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (v.gap > 0 && lat == 5) chk("en_low_in_ready", in_ready, 0);
            if (v.gap > 0 && lat == 4) en = 1'b0;
            if (v.gap > 0 && lat == 4 + v.gap) en = 1'b1;
        end while (!out_valid && lat < 40);
        chk("latency", lat, v.lat);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("sum", sum, e.s);
            chk("cout", cout, e.c);
`ifdef SERIAL_ADDER_OVF_EN
            chk("ovf", ovf, e.o);
`endif
        end
        chk("done_in_ready", in_ready, 0);
        if (v.stall > 0) begin
            hs = sum; hc = cout;
            in_valid = 1'b1; a = ~v.a;
            for (int i = 0; i < v.stall; i++) begin
                @(negedge clk);
                chk("stall_valid", out_valid, 1);
                chk("stall_sum", sum, hs);
                chk("stall_cout", cout, hc);
                chk("stall_in_ready", in_ready, 0);
            end
            in_valid = 1'b0; out_ready = 1'b1;
        end
        @(negedge clk);
        chk("consumed", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic [W:0] full;
        int         seen;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 0, 0,  9, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 0, 0,  9, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 0, 0,  9, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 0, 0,  9, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 0, 0,  9, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h55, 8'hAA, 1'b1, 0, 0,  9, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h3C, 8'hC3, 1'b0, 5, 0,  9, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'h12, 8'h34, 1'b1, 0, 3, 12, 8'h47, 1'b0, 1'b0};
        vecs[8] = '{8'h00, 8'h00, 1'b0, 0, 0,  9, 8'h00, 1'b0, 1'b0};
        vecs[9] = '{8'h40, 8'h40, 1'b0, 0, 0,  9, 8'h80, 1'b0, 1'b1};

        // Reset wins over en low and a pending request.
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        a = 8'h5A; b = 8'hA5; cin = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1; en = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Request held while en low must not load.
        en = 1'b0; in_valid = 1'b1; a = vecs[0].a; b = vecs[0].b; cin = vecs[0].ci;
        #1;
        chk("en_low_idle_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        chk("en_low_no_load", busy, 0);
        en = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            v.a = W'($urandom); v.b = W'($urandom); v.ci = 1'($urandom);
            v.stall = 0; v.gap = 0; v.lat = 9;
            full = {1'b0, v.a} + {1'b0, v.b} + {{W{1'b0}}, v.ci};
            v.s = full[W-1:0]; v.c = full[W];
            v.o = (v.a[W-1] == v.b[W-1]) && (v.s[W-1] != v.a[W-1]);
            run_op(v);
        end

        // Reset in the middle of RUN discards the operation.
        a = 8'hAA; b = 8'h11; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_run_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("midrst_no_result", seen, 0);
        v = '{8'h03, 8'h05, 1'b0, 0, 0, 9, 8'h08, 1'b0, 1'b0};
        run_op(v);

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
